// File: rtl/arith_unit_mc.sv
// Multi-cycle arithmetic slice: single-cycle add/sub, iterative shift-add
// multiply and restoring divide with a start/busy/done handshake.
module arith_unit_mc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A_Arith,
  input  logic [DATA_WIDTH-1:0] B_Arith,
  input  logic                  Arith_En,
  input  logic [1:0]            ALU_FUN_LS,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] Arith_OUT,
  output logic [DATA_WIDTH-1:0] Carry_OUT,
  output logic                  Arith_Flag,
  output logic                  Div_Zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    hi_reg;
  logic [W-1:0]    lo_reg;
  logic            accept;
  logic            last_step;
  logic [2*W-1:0]  step_res;

  // Full-width sum: carry-out lands in bit 0 of the high word.
  function automatic logic [2*W-1:0] add_full(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {{(W-1){1'b0}}, s};
  endfunction

  // Difference sign-extended to 2W bits.
  function automatic logic [2*W-1:0] sub_full(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return {{W{a < b}}, d};
  endfunction

  // One shift-add step; {hi,lo} holds partial product above remaining multiplier bits.
  function automatic logic [2*W-1:0] mul_step(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                              input logic [W-1:0] mcand);
    logic [W:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    return {sum[W:1], sum[0], lo[W-1:1]};
  endfunction

  // One restoring step; hi is the partial remainder, lo shifts dividend out / quotient in.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                              input logic [W-1:0] dvsr);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {hi, lo[W-1]};
    diff = sh - {1'b0, dvsr};
    if (sh >= {1'b0, dvsr})
      return {diff[W-1:0], lo[W-2:0], 1'b1};
    else
      return {sh[W-1:0], lo[W-2:0], 1'b0};
  endfunction

  assign accept    = (state == IDLE) && Arith_En;
  assign last_step = (cnt == LAST);
  assign Busy      = (state != IDLE);

  // Iteration result for whichever multi-cycle op is in flight
  always_comb begin
    step_res = mul_step(hi_reg, lo_reg, b_reg);
    if (state == DIV)
      step_res = div_step(hi_reg, lo_reg, b_reg);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: only mul and non-zero divide leave IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Arith_En && ALU_FUN_LS == 2'b10)
          state_nxt = MUL;
        else if (Arith_En && ALU_FUN_LS == 2'b11 && B_Arith != '0)
          state_nxt = DIV;
      end
      MUL, DIV: if (last_step) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      Arith_OUT  <= '0;
      Carry_OUT  <= '0;
      Arith_Flag <= 1'b0;
      Div_Zero   <= 1'b0;
    end else begin
      Arith_Flag <= 1'b0;
      if (accept) begin
        cnt      <= '0;
        b_reg    <= B_Arith;
        hi_reg   <= '0;
        lo_reg   <= A_Arith;
        Div_Zero <= (ALU_FUN_LS == 2'b11) && (B_Arith == '0);
        case (ALU_FUN_LS)
          2'b00: begin
            {Carry_OUT, Arith_OUT} <= add_full(A_Arith, B_Arith);
            Arith_Flag             <= 1'b1;
          end
          2'b01: begin
            {Carry_OUT, Arith_OUT} <= sub_full(A_Arith, B_Arith);
            Arith_Flag             <= 1'b1;
          end
          2'b11: begin
            if (B_Arith == '0) begin
              Arith_OUT  <= '1;
              Carry_OUT  <= A_Arith;
              Arith_Flag <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (state != IDLE) begin
        {hi_reg, lo_reg} <= step_res;
        cnt              <= cnt + CW'(1);
        if (last_step) begin
          {Carry_OUT, Arith_OUT} <= step_res;
          Arith_Flag             <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_mc.sv
// Bench for arith_unit_mc: directed vector table, hand-written handshake and
// reset sequences, and a randomized run against a behavioural model.
module tb_arith_unit_mc;

  localparam int W  = 8;
  localparam int NV = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         en;
  logic [1:0]   op;
  logic         busy, flag, dz;
  logic [W-1:0] aout, cout;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic         dz;
    int           edges;
    logic         noise;
  } vec_t;

  vec_t vecs[NV];

  arith_unit_mc #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A_Arith(a), .B_Arith(b), .Arith_En(en),
    .ALU_FUN_LS(op), .Busy(busy), .Arith_OUT(aout), .Carry_OUT(cout),
    .Arith_Flag(flag), .Div_Zero(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions
  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] lo, output logic [W-1:0] hi, output logic z);
    logic [31:0] p;
    z = 1'b0;
    p = '0;
    case (o)
      2'd0: begin p = 32'(x) + 32'(y); lo = p[7:0]; hi = p[15:8]; end
      2'd1: begin lo = x - y; hi = (x < y) ? 8'hFF : 8'h00; end
      2'd2: begin p = 32'(x) * 32'(y); lo = p[7:0]; hi = p[15:8]; end
      default: begin
        if (y == 0) begin lo = 8'hFF; hi = x; z = 1'b1; end
        else begin lo = x / y; hi = x % y; end
      end
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    a = v.a; b = v.b; op = v.op; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k <= v.edges; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < v.edges) begin
        chk({name, "_busy"}, 32'({busy, flag}), 32'(2'b10));
        if (v.noise) begin
          a  = 8'($urandom);
          b  = 8'($urandom);
          op = 2'($urandom);
          en = 1'($urandom_range(0, 1));
        end
      end else begin
        chk({name, "_res"}, 32'({busy, flag, dz, cout, aout}), 32'({1'b0, 1'b1, v.dz, v.hi, v.lo}));
      end
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk({name, "_hold"}, 32'({busy, flag, dz, cout, aout}), 32'({1'b0, 1'b0, v.dz, v.hi, v.lo}));
  endtask

  logic [W-1:0] m_lo, m_hi, p_lo, p_hi, t_lo, t_hi;
  logic         m_dz, m_flag, t_dz;
  int           m_cnt;

  initial begin
    vecs[0] = '{2'd0, 8'd200, 8'd100, 8'h2C, 8'h01, 1'b0, 0, 1'b0};
    vecs[1] = '{2'd1, 8'd5,   8'd7,   8'hFE, 8'hFF, 1'b0, 0, 1'b0};
    vecs[2] = '{2'd2, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, W, 1'b1};
    vecs[3] = '{2'd3, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, W, 1'b1};
    vecs[4] = '{2'd3, 8'd13,  8'd0,   8'hFF, 8'h0D, 1'b1, 0, 1'b0};
    vecs[5] = '{2'd0, 8'd1,   8'd1,   8'h02, 8'h00, 1'b0, 0, 1'b0};
    vecs[6] = '{2'd3, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, W, 1'b0};
    vecs[7] = '{2'd2, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, W, 1'b0};
    vecs[8] = '{2'd1, 8'd7,   8'd5,   8'h02, 8'h00, 1'b0, 0, 1'b0};
    vecs[9] = '{2'd3, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0, W, 1'b1};

    rst = 1'b1; en = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({busy, flag, dz, cout, aout}), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'({busy, flag, dz, cout, aout}), 32'(0));

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back subtracts keep the flag high with fresh results
    @(negedge clk);
    a = 8'd5; b = 8'd7; op = 2'd1; en = 1'b1;
    @(posedge clk); #1;
    chk("b2b_sub1", 32'({flag, cout, aout}), 32'({1'b1, 8'hFF, 8'hFE}));
    a = 8'd7; b = 8'd5;
    @(posedge clk); #1;
    chk("b2b_sub2", 32'({flag, cout, aout}), 32'({1'b1, 8'h00, 8'h02}));
    en = 1'b0;
    @(posedge clk); #1;
    chk("b2b_flag_drop", 32'(flag), 32'(0));

    // New op accepted in the cycle the multiply result flag is high
    @(negedge clk);
    a = 8'd2; b = 8'd3; op = 2'd2; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    chk("mul_then_flag", 32'({busy, flag, cout, aout}), 32'({1'b0, 1'b1, 8'h00, 8'h06}));
    a = 8'd10; b = 8'd20; op = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    chk("accept_on_flag", 32'({busy, flag, cout, aout}), 32'({1'b0, 1'b1, 8'h00, 8'h1E}));
    en = 1'b0;

    // Reset mid-multiply clears everything without waiting for an edge
    @(negedge clk);
    a = 8'd3; b = 8'd4; op = 2'd2; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 32'({busy, flag, dz, cout, aout}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("no_flag_after_abort", 32'({busy, flag, cout, aout}), 32'(0));
    end
    run_vec('{2'd0, 8'd3, 8'd4, 8'h07, 8'h00, 1'b0, 0, 1'b0}, "add_after_reset");

    // Randomized regression against the behavioural model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lo = '0; m_hi = '0; m_dz = 1'b0; m_flag = 1'b0; m_cnt = 0; p_lo = '0; p_hi = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      @(posedge clk);
      if (m_cnt > 0) begin
        m_cnt--;
        m_flag = (m_cnt == 0);
        if (m_cnt == 0) begin m_lo = p_lo; m_hi = p_hi; end
      end else begin
        m_flag = 1'b0;
        if (en) begin
          ref_op(op, a, b, t_lo, t_hi, t_dz);
          m_dz = t_dz;
          if (op < 2 || t_dz) begin
            m_lo = t_lo; m_hi = t_hi; m_flag = 1'b1;
          end else begin
            p_lo = t_lo; p_hi = t_hi; m_cnt = W;
          end
        end
      end
      #1;
      chk($sformatf("rand%0d", c), 32'({busy, flag, dz, cout, aout}),
          32'({m_cnt > 0, m_flag, m_dz, m_hi, m_lo}));
    end
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_unit_mc.md
Name: arith_unit_mc

Overview:
Parametrised multi-cycle arithmetic unit. It is the next-generation arithmetic slice of the system ALU.
- Add and subtract complete in a single registered cycle.
- Multiply is iterative shift-add; divide is iterative restoring division. Both take DATA_WIDTH cycles, which replaces the wide combinational multiplier/divider.
- Adds a start/busy/done handshake, operand capture, remainder output and divide-by-zero detection.

Parameters:
DATA_WIDTH, 8, operand width; results are 2*DATA_WIDTH split over two output words; must be >= 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
A_Arith  input  DATA_WIDTH  operand A (unsigned)
B_Arith  input  DATA_WIDTH  operand B (unsigned)
Arith_En  input  1  start request; sampled on rising clk edge
ALU_FUN_LS  input  2  00 add, 01 sub, 10 mul, 11 div
Busy  output  1  high while a multi-cycle op is in progress
Arith_OUT  output  DATA_WIDTH  low result word / quotient
Carry_OUT  output  DATA_WIDTH  high result word / remainder
Arith_Flag  output  1  one-cycle result-valid pulse
Div_Zero  output  1  divide-by-zero indication, valid with the result

Behaviour:
- Reset (async, rst=1):
  - State -> IDLE.
  - Busy, Arith_OUT, Carry_OUT, Arith_Flag, Div_Zero all 0; internal counter and operand registers cleared.
  - Reset mid-operation aborts the operation; no Arith_Flag is produced for it.
- States: IDLE, MUL, DIV. Iteration counter is ceil(log2(DATA_WIDTH+1)) bits.
- Accept edge E0 = rising edge with state IDLE and Arith_En=1.
  - A, B and ALU_FUN_LS are captured at E0; input changes afterwards are ignored until the result.
  - Div_Zero clears at every accept edge, unless that op itself is a divide by zero.
- Add (00):
  - At E0: Arith_OUT = (A+B) mod 2^W; Carry_OUT = {0.., carry-out bit}; Arith_Flag=1.
  - State stays IDLE.
- Sub (01):
  - At E0: Arith_OUT = (A-B) mod 2^W.
  - Carry_OUT = all ones if A<B, else 0 (sign extension of the 2W-bit difference).
  - Arith_Flag=1; state stays IDLE.
- Mul (10):
  - E0 -> MUL, Busy=1.
  - Edges E1..EW each perform one shift-add step (LSB of multiplier first).
  - At EW: {Carry_OUT,Arith_OUT} = A*B (full 2W-bit product); Arith_Flag=1; Busy=0; state -> IDLE.
- Div (11), B != 0:
  - E0 -> DIV, Busy=1.
  - Edges E1..EW each perform one restoring step (MSB of dividend first).
  - At EW: Arith_OUT = A/B; Carry_OUT = A%B; Arith_Flag=1; Busy=0; state -> IDLE.
- Div (11), B = 0:
  - Single cycle at E0, no Busy.
  - Arith_OUT = all ones; Carry_OUT = A; Div_Zero=1; Arith_Flag=1.
- Latency from accept edge to Arith_Flag high:
  - Add/sub/div-by-zero: 1 cycle.
  - Mul/div: DATA_WIDTH cycles; Busy is high for exactly DATA_WIDTH cycles.
- Arith_Flag:
  - High exactly one cycle per accepted op; deasserts at the next edge unless a new single-cycle op is accepted there.
  - Back-to-back add/sub gives a continuous Flag with a new result each cycle.
- Arith_En while Busy=1 is ignored (dropped, not queued).
- Arith_En in the cycle Arith_Flag is high (Busy already low) is accepted normally.
- Arith_OUT, Carry_OUT and Div_Zero hold their last value until the next result edge.
  - Intermediate iteration values never appear on the outputs.

Test Plan (DATA_WIDTH=8):
1. Add A=200, B=100 -> one cycle after accept: Arith_OUT=0x2C, Carry_OUT=0x01, Arith_Flag pulse 1 cycle, Busy stays 0.
2. Sub A=5, B=7 -> Arith_OUT=0xFE, Carry_OUT=0xFF; then Sub A=7, B=5 the next cycle -> 0x02/0x00 with Flag continuously high for 2 cycles.
3. Mul A=255, B=255 -> Busy high 8 cycles, then Arith_OUT=0x01, Carry_OUT=0xFE, Flag 8 cycles after accept; A/B toggled and Arith_En pulsed during Busy have no effect.
4. Div A=200, B=7 -> after 8 cycles Arith_OUT=0x1C, Carry_OUT=0x04, Div_Zero=0; Div A=13, B=0 -> 1 cycle: Arith_OUT=0xFF, Carry_OUT=0x0D, Div_Zero=1; next Add 1+1 -> Div_Zero=0.
5. Start Mul 3*4, assert rst after 4 cycles -> all outputs 0 immediately (asynchronously), no Flag; after release, Add 3+4 -> Arith_OUT=0x07 in 1 cycle.
6. Random regression across all 4 ops with random operands and random Arith_En (including during Busy) vs. reference model -> exact match of outputs and latency.
